// File: rtl/msi_message_generator.sv
// MSI message generator: latches per-vector requests, applies per-vector masks,
// and issues one MSI memory write at a time, picking vectors round-robin.
module msi_message_generator #(
    parameter int MAX_VECTORS = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   msi_enable,
    input  logic [2:0]             multiple_message_enable,
    input  logic                   addr_64bit_capable,
    input  logic [63:0]            message_address,
    input  logic [15:0]            message_data,
    input  logic [MAX_VECTORS-1:0] mask_bits,
    input  logic [MAX_VECTORS-1:0] irq_req,
    output logic [MAX_VECTORS-1:0] pending_bits,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [63:0]            tx_addr,
    output logic [31:0]            tx_data,
    output logic                   tx_is_64bit,
    output logic                   busy
);

    localparam int VW = $clog2(MAX_VECTORS);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             mme_c;
    logic [MAX_VECTORS-1:0] alloc_mask;
    logic [MAX_VECTORS-1:0] eligible;
    logic [MAX_VECTORS-1:0] pending_q;
    logic [MAX_VECTORS-1:0] grant_onehot;
    logic [VW-1:0]          last_grant_q;
    logic [VW-1:0]          grant_idx;
    logic [VW-1:0]          cand;
    logic                   grant_found;
    logic                   grant_take;
    logic [15:0]            low_mask;
    logic [31:0]            addr_upper;

    assign mme_c = (multiple_message_enable > 3'd5) ? 3'd5 : multiple_message_enable;

    always_comb begin
        alloc_mask = '0;
        for (int unsigned i = 0; i < MAX_VECTORS; i++) begin
            alloc_mask[i] = (i < (32'd1 << mme_c));
        end
    end

    assign eligible = pending_q & ~mask_bits & alloc_mask;

    // Round-robin: scan starting one past the last granted vector, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < MAX_VECTORS; k++) begin
            cand = VW'((32'(last_grant_q) + 32'd1 + k) % MAX_VECTORS);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (msi_enable && grant_found) begin
                    grant_take = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_onehot = '0;
        if (grant_take) grant_onehot[grant_idx] = 1'b1;
    end

    assign low_mask   = 16'((32'd1 << mme_c) - 32'd1);
    assign addr_upper = addr_64bit_capable ? message_address[63:32] : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A new request on the vector being granted wins over the grant's clear.
    always_ff @(posedge clk) begin
        if (rst || !msi_enable) pending_q <= '0;
        else pending_q <= (pending_q & ~grant_onehot) | (irq_req & alloc_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= VW'(MAX_VECTORS - 1);
            tx_addr      <= '0;
            tx_data      <= '0;
            tx_is_64bit  <= 1'b0;
        end else if (grant_take) begin
            last_grant_q <= grant_idx;
            tx_addr      <= {addr_upper, message_address[31:2], 2'b00};
            tx_data      <= {16'h0, (message_data & ~low_mask) | 16'(grant_idx)};
            tx_is_64bit  <= (addr_upper != 32'h0);
        end
    end

    assign tx_valid     = (state_q == SEND);
    assign busy         = (state_q == SEND);
    assign pending_bits = pending_q;

endmodule
